// File: rtl/fmul_float_cal_pipe_if.sv
// rtl/fmul_float_cal_pipe_if.sv - operand/result handshake bundle for the float multiply core
interface fmul_float_cal_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int OP_W = 1 + EXP_W + MAN_W;

  logic                 iDATA_REQ;
  logic                 oDATA_BUSY;
  logic [OP_W-1:0]      iDATA_A;
  logic [OP_W-1:0]      iDATA_B;
  logic [TAG_W-1:0]     iDATA_TAG;
  logic                 oDATA_VALID;
  logic                 iDATA_BUSY;
  logic                 oDATA_SIGN;
  logic [EXP_W+1:0]     oDATA_EXP;
  logic [2*MAN_W+1:0]   oDATA_FRACT;
  logic [TAG_W-1:0]     oDATA_TAG;
  logic [5:0]           oDATA_EXCEPT;

  modport master (
    output iDATA_REQ, iDATA_A, iDATA_B, iDATA_TAG, iDATA_BUSY,
    input  oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP, oDATA_FRACT, oDATA_TAG, oDATA_EXCEPT
  );

  modport slave (
    input  iDATA_REQ, iDATA_A, iDATA_B, iDATA_TAG, iDATA_BUSY,
    output oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP, oDATA_FRACT, oDATA_TAG, oDATA_EXCEPT
  );
endinterface

// File: rtl/fmul_float_cal_pipe.sv
// rtl/fmul_float_cal_pipe.sv - float multiply sign/exponent/mantissa-product core with elastic pipeline
// Raw product and biased-corrected exponent go to the normaliser; no special-case resolution here.
module fmul_float_cal_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic                  iRESET_SYNC,
  fmul_float_cal_pipe_if.slave  bus
);

  localparam int OP_W = 1 + EXP_W + MAN_W;
  localparam int XE_W = EXP_W + 2;
  localparam int FR_W = 2 * MAN_W + 2;
  localparam logic [XE_W-1:0] BIAS = XE_W'((1 << (EXP_W - 1)) - 1);

  typedef struct packed {
    logic              sign;
    logic [XE_W-1:0]   exp;
    logic [FR_W-1:0]   fract;
    logic [TAG_W-1:0]  tag;
    logic [5:0]        except;
  } stage_t;

  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             hid_a, hid_b;
  stage_t           op_d;

  assign exp_a = bus.iDATA_A[OP_W-2:MAN_W];
  assign exp_b = bus.iDATA_B[OP_W-2:MAN_W];
  assign man_a = bus.iDATA_A[MAN_W-1:0];
  assign man_b = bus.iDATA_B[MAN_W-1:0];
  // Subnormals keep the raw exponent field; only the hidden bit drops to 0.
  assign hid_a = |exp_a;
  assign hid_b = |exp_b;

  always_comb begin
    op_d        = '0;
    op_d.sign   = bus.iDATA_A[OP_W-1] ^ bus.iDATA_B[OP_W-1];
    op_d.exp    = XE_W'(exp_a) + XE_W'(exp_b) - BIAS;
    op_d.fract  = FR_W'({hid_a, man_a}) * FR_W'({hid_b, man_b});
    op_d.tag    = bus.iDATA_TAG;
    op_d.except = {exp_a == '0, exp_b == '0, &exp_a, &exp_b, man_a == '0, man_b == '0};
  end

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [LATENCY-1:0] rdy;
  stage_t             data_q [LATENCY];
  stage_t             data_d [LATENCY];

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign valid_d[k] = bus.iDATA_REQ;
      assign data_d[k]  = op_d;
    end else begin : g_body
      assign valid_d[k] = valid_q[k-1];
      assign data_d[k]  = data_q[k-1];
    end
    // A stage can only be blocked if it and every stage after it is full and the sink stalls.
    assign rdy[k] = ~(bus.iDATA_BUSY & (&valid_q[LATENCY-1:k]));
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      valid_q <= '0;
      for (int k = 0; k < LATENCY; k++) data_q[k] <= '0;
    end else if (iRESET_SYNC) begin
      valid_q <= '0;
      for (int k = 0; k < LATENCY; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= valid_d[k];
          if (valid_d[k]) data_q[k] <= data_d[k];
        end
      end
    end
  end

  assign bus.oDATA_BUSY   = ~rdy[0];
  assign bus.oDATA_VALID  = valid_q[LATENCY-1];
  assign bus.oDATA_SIGN   = data_q[LATENCY-1].sign;
  assign bus.oDATA_EXP    = data_q[LATENCY-1].exp;
  assign bus.oDATA_FRACT  = data_q[LATENCY-1].fract;
  assign bus.oDATA_TAG    = data_q[LATENCY-1].tag;
  assign bus.oDATA_EXCEPT = data_q[LATENCY-1].except;

endmodule

// File: tb/tb_fmul_float_cal_pipe.sv
// tb/tb_fmul_float_cal_pipe.sv - vector, corner-sequence and random scoreboard bench for the multiply core
module tb_fmul_float_cal_pipe;
  localparam int EXP_W = 8, MAN_W = 23, LATENCY = 2, TAG_W = 4;

  logic iCLOCK = 1'b0;
  logic inRESET = 1'b0;
  logic iRESET_SYNC = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  fmul_float_cal_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fmul_float_cal_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC), .bus(bus)
  );

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] fract;
    logic [3:0]  tag;
    logic [5:0]  exc;
  } res_t;
  typedef struct { res_t r; int age; } ent_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] tag; res_t exp; } vec_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    res_t r;
    int ea, eb;
    longint unsigned ma, mb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = {41'd0, a[22:0]} + ((ea != 0) ? 64'd8388608 : 64'd0);
    mb = {41'd0, b[22:0]} + ((eb != 0) ? 64'd8388608 : 64'd0);
    r.sign  = a[31] ^ b[31];
    r.exp   = 10'(ea + eb - 127);
    r.fract = 48'(ma * mb);
    r.tag   = tag;
    r.exc   = {ea == 0, eb == 0, ea == 255, eb == 255, a[22:0] == 23'd0, b[22:0] == 23'd0};
    return r;
  endfunction

  function automatic res_t dut_res();
    return {bus.oDATA_SIGN, bus.oDATA_EXP, bus.oDATA_FRACT, bus.oDATA_TAG, bus.oDATA_EXCEPT};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: r[22:0]  = 23'd0;
      default: ;
    endcase
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                              input logic s, input logic [9:0] e, input logic [47:0] f, input logic [5:0] x);
    vec_t v;
    v.a = a; v.b = b; v.tag = tag;
    v.exp.sign = s; v.exp.exp = e; v.exp.fract = f; v.exp.tag = tag; v.exp.exc = x;
    return v;
  endfunction

  // One clock cycle: drive, check against the scoreboard, then advance the model past the edge.
  task automatic step(input logic req, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input logic dbusy, output logic acc, output logic popped, output logic [3:0] ptag,
                      output res_t pres, output logic obusy);
    logic exp_busy, exp_valid;
    ent_t e;
    @(negedge iCLOCK);
    bus.iDATA_REQ = req; bus.iDATA_A = a; bus.iDATA_B = b; bus.iDATA_TAG = tag; bus.iDATA_BUSY = dbusy;
    #1;
    exp_busy  = (q.size() == LATENCY) && dbusy;
    exp_valid = (q.size() != 0) && (q[0].age >= LATENCY);
    obusy = bus.oDATA_BUSY;
    chk("busy", 128'(bus.oDATA_BUSY), 128'(exp_busy));
    chk("valid", 128'(bus.oDATA_VALID), 128'(exp_valid));
    popped = 1'b0; ptag = '0; pres = dut_res();
    if (exp_valid) begin
      chk("result", 128'(dut_res()), 128'(q[0].r));
      popped = !dbusy;
      ptag = q[0].r.tag;
    end
    acc = req && !exp_busy;
    @(posedge iCLOCK);
    if (popped) void'(q.pop_front());
    foreach (q[i]) begin e = q[i]; e.age++; q[i] = e; end
    if (acc) begin e.r = ref_model(a, b, tag); e.age = 1; q.push_back(e); end
  endtask

  vec_t vecs[7];
  logic acc, popped, obusy, have, saw_busy;
  logic [3:0] ptag, rtag;
  logic [31:0] ra, rb;
  res_t pres;
  int n, idx;
  logic [3:0] seen[$];

  initial begin
    vecs[0] = mk(32'h3FC00000, 32'h40000000, 4'd5, 1'b0, 10'd128,  48'h6000_0000_0000, 6'b000001);
    vecs[1] = mk(32'h00800000, 32'h80800000, 4'd9, 1'b1, 10'h383,  48'h4000_0000_0000, 6'b000011);
    vecs[2] = mk(32'h7F800000, 32'h00000000, 4'd3, 1'b0, 10'd128,  48'h0,              6'b011011);
    vecs[3] = mk(32'hC0400000, 32'hBF800000, 4'd7, 1'b0, 10'd128,  48'h6000_0000_0000, 6'b000001);
    vecs[4] = mk(32'h00400000, 32'h3F800000, 4'd2, 1'b0, 10'd0,    48'h2000_0000_0000, 6'b100001);
    vecs[5] = mk(32'h7FC00000, 32'hFF800000, 4'd14, 1'b1, 10'h17F, 48'h6000_0000_0000, 6'b001101);
    vecs[6] = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 4'd15, 1'b0, 10'h17D, 48'hFFFF_FE00_0001, 6'b000000);

    bus.iDATA_REQ = 0; bus.iDATA_A = '0; bus.iDATA_B = '0; bus.iDATA_TAG = '0; bus.iDATA_BUSY = 0;
    repeat (2) @(posedge iCLOCK);
    #1;
    chk("rst_valid", 128'(bus.oDATA_VALID), 128'(0));
    chk("rst_busy", 128'(bus.oDATA_BUSY), 128'(0));
    chk("rst_data", 128'(dut_res()), 128'(0));
    @(negedge iCLOCK);
    inRESET = 1;

    // Directed vectors, one op at a time, with latency measured in cycles.
    for (int i = 0; i < 7; i++) begin
      step(1, vecs[i].a, vecs[i].b, vecs[i].tag, 0, acc, popped, ptag, pres, obusy);
      chk("vec_accept", 128'(acc), 128'(1));
      n = 0; popped = 0;
      while (!popped && n < 8) begin
        step(0, '0, '0, '0, 0, acc, popped, ptag, pres, obusy);
        n++;
      end
      chk("vec_latency", 128'(n), 128'(LATENCY));
      chk($sformatf("vec%0d", i), 128'(pres), 128'(vecs[i].exp));
    end

    // Back-to-back tags 0..5 with a downstream stall on cycles 3..5.
    idx = 0; saw_busy = 0;
    seen.delete();
    for (int cyc = 0; cyc < 30 && (idx < 6 || q.size() != 0); cyc++) begin
      step(idx < 6, 32'h3F800000 + (idx << 20), 32'h40400000, 4'(idx), (cyc >= 3 && cyc <= 5),
           acc, popped, ptag, pres, obusy);
      saw_busy |= obusy;
      if (acc) idx++;
      if (popped) seen.push_back(ptag);
    end
    chk("stream_count", 128'(seen.size()), 128'(6));
    chk("stream_busy_seen", 128'(saw_busy), 128'(1));
    foreach (seen[i]) chk("stream_order", 128'(seen[i]), 128'(i));

    // Bubble collapse: second op enters while the first is stalled ahead of it.
    step(1, 32'h40000000, 32'h40000000, 4'd1, 1, acc, popped, ptag, pres, obusy);
    chk("bub_acc1", 128'(acc), 128'(1));
    step(1, 32'h40400000, 32'h40000000, 4'd2, 1, acc, popped, ptag, pres, obusy);
    chk("bub_acc2", 128'(acc), 128'(1));
    chk("bub_nobusy", 128'(obusy), 128'(0));
    step(0, '0, '0, '0, 1, acc, popped, ptag, pres, obusy);
    chk("bub_full_busy", 128'(obusy), 128'(1));
    step(0, '0, '0, '0, 0, acc, popped, ptag, pres, obusy);
    chk("bub_pop1", 128'({popped, ptag}), 128'({1'b1, 4'd1}));
    step(0, '0, '0, '0, 0, acc, popped, ptag, pres, obusy);
    chk("bub_pop2", 128'({popped, ptag}), 128'({1'b1, 4'd2}));

    // Synchronous reset with two ops in flight.
    step(1, 32'h3F800000, 32'h3F800000, 4'd4, 0, acc, popped, ptag, pres, obusy);
    step(1, 32'h3F800000, 32'h40000000, 4'd6, 0, acc, popped, ptag, pres, obusy);
    @(negedge iCLOCK);
    bus.iDATA_REQ = 0; iRESET_SYNC = 1;
    @(posedge iCLOCK);
    #1;
    chk("srst_valid", 128'(bus.oDATA_VALID), 128'(0));
    chk("srst_busy", 128'(bus.oDATA_BUSY), 128'(0));
    chk("srst_data", 128'(dut_res()), 128'(0));
    @(negedge iCLOCK);
    iRESET_SYNC = 0;
    q.delete();

    // Asynchronous reset mid-cycle with a full, stalled pipe.
    step(1, 32'h3F800000, 32'h3F800000, 4'd8, 1, acc, popped, ptag, pres, obusy);
    step(1, 32'h3F800000, 32'h40000000, 4'd10, 1, acc, popped, ptag, pres, obusy);
    @(negedge iCLOCK);
    bus.iDATA_REQ = 0;
    #2 inRESET = 0;
    #1;
    chk("arst_valid", 128'(bus.oDATA_VALID), 128'(0));
    chk("arst_busy", 128'(bus.oDATA_BUSY), 128'(0));
    chk("arst_data", 128'(dut_res()), 128'(0));
    @(negedge iCLOCK);
    inRESET = 1;
    bus.iDATA_BUSY = 0;
    q.delete();
    @(posedge iCLOCK);
    #1;
    chk("arst_after", 128'(bus.oDATA_VALID), 128'(0));

    // Random traffic and backpressure; the source holds a refused op.
    have = 0; ra = '0; rb = '0; rtag = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!have) begin
        have = ($urandom_range(0, 3) != 0);
        ra = rand_op(); rb = rand_op(); rtag = 4'($urandom);
      end
      step(have, ra, rb, rtag, ($urandom_range(0, 2) == 0), acc, popped, ptag, pres, obusy);
      if (acc) have = 0;
    end
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step(0, '0, '0, '0, 0, acc, popped, ptag, pres, obusy);
    chk("drain_empty", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
